// File: rtl/cfg_arb_pkg.sv
// cfg_arb_pkg: shared FSM state type and default sizing for the config register arbiter
package cfg_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DEPTH = 24;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant searching upward from ptr_i
//   req_i   : request vector
//   ptr_i   : highest-priority requester index
//   grant_o : one-hot grant, idx_o : its index
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IW-1:0]      idx_o
);
  always_comb begin
    logic [IW-1:0] j;
    j = '0;
    grant_o = '0;
    idx_o = '0;
    // walk from the furthest candidate back to ptr_i so the nearest request wins
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = IW'((int'(ptr_i) + i) % NUM_REQ);
      if (req_i[j]) begin
        grant_o = '0;
        grant_o[j] = 1'b1;
        idx_o = j;
      end
    end
  end
endmodule

// File: rtl/cfg_reg_arbiter.sv
// cfg_reg_arbiter: round-robin arbiter giving NUM_REQ requesters one-at-a-time access to a config register file
//   req_*  : per-requester valid/ready handshake with flattened wr/addr/wdata
//   rsp_*  : one-hot completion pulse to the owner with shared read data and error flag
//   cfg_*  : register file port; cs_n low for one ISSUE cycle, then wait for cfg_resp
module cfg_reg_arbiter
  import cfg_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int TIMEOUT    = 15
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          cfg_cs_n,
  output logic                          cfg_wr_en,
  output logic [ADDR_WIDTH-1:0]         cfg_addr,
  output logic [DATA_WIDTH-1:0]         cfg_wr_data,
  input  logic [DATA_WIDTH-1:0]         cfg_rd_data,
  input  logic                          cfg_resp
);
  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_e state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, gnt_q, gnt_d, gidx;
  logic [NUM_REQ-1:0] grant;
  logic wr_q, wr_d, err_q, err_d, sel_wr, bad, expire;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, sel_addr;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d, sel_wdata;
  logic [CW-1:0] cnt_q, cnt_d;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
    .req_i  (req_valid),
    .ptr_i  (ptr_q),
    .grant_o(grant),
    .idx_o  (gidx)
  );
  always_comb begin
    sel_addr = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    sel_wr = |(req_wr & grant);
    bad = int'(sel_addr) >= DEPTH;
    expire = cnt_q == CW'(TIMEOUT - 1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      gnt_q <= '0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    gnt_d = gnt_q;
    wr_d = wr_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d = err_q;
    cnt_d = '0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          // out-of-range addresses never reach the register file
          state_d = bad ? RESP : ISSUE;
          ptr_d = (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
          gnt_d = gidx;
          wr_d = sel_wr;
          addr_d = sel_addr;
          wdata_d = sel_wdata;
          rdata_d = '0;
          err_d = bad;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        state_d = (cfg_resp || expire) ? RESP : WAIT;
        cnt_d = (cfg_resp || expire) ? '0 : cnt_q + 1'b1;
        rdata_d = (cfg_resp && !wr_q) ? cfg_rd_data : '0;
        err_d = !cfg_resp;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    req_ready = (rst_n && state_q == IDLE) ? grant : '0;
    rsp_valid = (state_q == RESP) ? NUM_REQ'(1) << gnt_q : '0;
    rsp_rdata = (state_q == RESP) ? rdata_q : '0;
    rsp_err = (state_q == RESP) && err_q;
    cfg_cs_n = state_q != ISSUE;
    cfg_wr_en = wr_q && (state_q == ISSUE || state_q == WAIT);
    cfg_addr = addr_q;
    cfg_wr_data = wdata_q;
  end
endmodule
